// File: rtl/instr_issuer_if.sv
// Instruction handshake bundle between the issuer (master) and the processor (slave).
interface instr_issuer_if #(
   parameter int B = 6
);
   logic         instr_valid;
   logic         instr_ready;
   logic [B-1:0] instr;

   modport master (output instr_valid, output instr, input instr_ready);
   modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/instr_issuer.sv
// Buffers a short program and replays it to a processor over a valid/ready link.
// Issue starts the edge after start; one word per cycle, each word held until instr_ready accepts it.
module instr_issuer #(
   parameter int B     = 6,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [B-1:0]  wr_data,
   input  logic          clear,
   input  logic          start,
   input  logic          loop,
   input  logic          abort,
   instr_issuer_if.master iss,
   output logic          full,
   output logic          busy,
   output logic          done,
   output logic [7:0]    issue_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [7:0]     issue_cnt_q, issue_cnt_d;
   logic [B-1:0]   mem_q [DEPTH];
   logic           wr_fire;
   logic           last;

   assign last = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      issue_cnt_d = issue_cnt_q;
      wr_fire     = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear) begin
               count_d = '0;
            end else begin
               if (wr_en && !full) begin
                  wr_fire = 1'b1;
                  count_d = count_q + CW'(1);
               end
               if (start && (count_q != '0)) begin
                  state_d  = RUN;
                  rd_ptr_d = '0;
               end
            end
         end
         RUN: begin
            if (iss.instr_ready) begin
               issue_cnt_d = issue_cnt_q + 8'd1;
               if (!last)
                  rd_ptr_d = rd_ptr_q + AW'(1);
               else if (loop)
                  rd_ptr_d = '0;
               else
                  state_d = DONE;
            end
            // abort wins over completion, so a last-word handshake with abort gives no done pulse
            if (abort)
               state_d = IDLE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         issue_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   // Storage needs no reset: unwritten entries are never presented.
   always_ff @(posedge clk) begin
      if (wr_fire)
         mem_q[count_q[AW-1:0]] <= wr_data;
   end

   assign iss.instr_valid = (state_q == RUN);
   assign iss.instr       = (state_q == RUN) ? mem_q[rd_ptr_q] : '0;
   assign full            = (count_q == CW'(DEPTH));
   assign busy            = (state_q == RUN);
   assign done            = (state_q == DONE);
   assign issue_cnt       = issue_cnt_q;
endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: program load, issue, backpressure, loop, abort, reset and counter wrap.
module tb_instr_issuer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [5:0] wr_data = '0;
   logic       clear = 1'b0;
   logic       start = 1'b0;
   logic       loop = 1'b0;
   logic       abort = 1'b0;
   logic       full, busy, done;
   logic [7:0] issue_cnt;

   int vec = 0;
   int errs = 0;
   logic [7:0] exp_cnt = 8'd0;

   instr_issuer_if #(.B(6)) bus ();

   instr_issuer #(.B(6), .DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .clear     (clear),
      .start     (start),
      .loop      (loop),
      .abort     (abort),
      .iss       (bus),
      .full      (full),
      .busy      (busy),
      .done      (done),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [5:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      bus.instr_ready = 1'b0;
      #3;
      vec++; if (bus.instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", bus.instr_valid); end
      vec++; if (bus.instr !== 6'h00) begin errs++; $display("FAIL rst_instr got %h want 00", bus.instr); end
      vec++; if ({done, busy, full} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b want 000", {done, busy, full}); end
      vec++; if (issue_cnt !== 8'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", issue_cnt); end
      tick();
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      write_word(6'h01);
      write_word(6'h02);
      write_word(6'h03);
      bus.instr_ready = 1'b1;
      loop  = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vec++; if (bus.instr_valid !== 1'b1 || bus.instr !== 6'(i + 1))
            begin errs++; $display("FAIL basic_word%0d got v=%b %h want v=1 %h", i, bus.instr_valid, bus.instr, 6'(i + 1)); end
         vec++; if (done !== 1'b0) begin errs++; $display("FAIL basic_nodone%0d got %b want 0", i, done); end
         tick();
         exp_cnt = exp_cnt + 8'd1;
      end
      vec++; if (done !== 1'b1 || bus.instr_valid !== 1'b0) begin errs++; $display("FAIL basic_done got d=%b v=%b want d=1 v=0", done, bus.instr_valid); end
      vec++; if (issue_cnt !== exp_cnt) begin errs++; $display("FAIL basic_cnt got %0d want %0d", issue_cnt, exp_cnt); end
      tick();
      vec++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL basic_idle got d=%b b=%b want 0 0", done, busy); end
   endtask

   task automatic test_full();
      do_clear();
      for (int i = 0; i < 8; i++) begin
         vec++; if (full !== 1'b0) begin errs++; $display("FAIL full_before%0d got %b want 0", i, full); end
         write_word(6'(i + 16));
      end
      vec++; if (full !== 1'b1) begin errs++; $display("FAIL full_at8 got %b want 1", full); end
      write_word(6'h3F);
      vec++; if (full !== 1'b1) begin errs++; $display("FAIL full_after9 got %b want 1", full); end
      bus.instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         vec++; if (bus.instr !== 6'(i + 16)) begin errs++; $display("FAIL full_word%0d got %h want %h", i, bus.instr, 6'(i + 16)); end
         tick();
         exp_cnt = exp_cnt + 8'd1;
      end
      vec++; if (done !== 1'b1) begin errs++; $display("FAIL full_done got %b want 1", done); end
      tick();
      clear = 1'b1;
      wr_en = 1'b1;
      wr_data = 6'h11;
      tick();
      clear = 1'b0;
      wr_en = 1'b0;
      vec++; if (full !== 1'b0) begin errs++; $display("FAIL full_clear got %b want 0", full); end
      start = 1'b1;
      tick();
      start = 1'b0;
      vec++; if (busy !== 1'b0 || bus.instr_valid !== 1'b0) begin errs++; $display("FAIL empty_start got b=%b v=%b want 0 0", busy, bus.instr_valid); end
      tick();
   endtask

   task automatic test_backpressure();
      write_word(6'h2A);
      write_word(6'h15);
      bus.instr_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vec++; if (bus.instr !== 6'h2A) begin errs++; $display("FAIL bp_w0 got %h want 2a", bus.instr); end
      tick();
      vec++; if (bus.instr !== 6'h2A || bus.instr_valid !== 1'b1) begin errs++; $display("FAIL bp_hold0 got v=%b %h want v=1 2a", bus.instr_valid, bus.instr); end
      bus.instr_ready = 1'b1;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      bus.instr_ready = 1'b0;
      vec++; if (bus.instr !== 6'h15) begin errs++; $display("FAIL bp_w1 got %h want 15", bus.instr); end
      tick();
      vec++; if (bus.instr !== 6'h15) begin errs++; $display("FAIL bp_hold1 got %h want 15", bus.instr); end
      bus.instr_ready = 1'b1;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      vec++; if (done !== 1'b1 || issue_cnt !== exp_cnt) begin errs++; $display("FAIL bp_done got d=%b cnt=%0d want d=1 cnt=%0d", done, issue_cnt, exp_cnt); end
      tick();
   endtask

   task automatic test_loop_abort();
      do_clear();
      write_word(6'h05);
      write_word(6'h33);
      loop = 1'b1;
      bus.instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         vec++; if (bus.instr !== ((i % 2) ? 6'h33 : 6'h05) || done !== 1'b0)
            begin errs++; $display("FAIL loop_hs%0d got %h d=%b want %h d=0", i, bus.instr, done, ((i % 2) ? 6'h33 : 6'h05)); end
         tick();
         exp_cnt = exp_cnt + 8'd1;
      end
      bus.instr_ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vec++; if (busy !== 1'b0 || done !== 1'b0 || bus.instr_valid !== 1'b0) begin errs++; $display("FAIL loop_abort got b=%b d=%b v=%b want 000", busy, done, bus.instr_valid); end
      vec++; if (issue_cnt !== exp_cnt) begin errs++; $display("FAIL loop_cnt got %0d want %0d", issue_cnt, exp_cnt); end
      // abort together with a handshake on the last word: counted, no done
      loop = 1'b0;
      bus.instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      vec++; if (busy !== 1'b0 || done !== 1'b0 || issue_cnt !== exp_cnt) begin errs++; $display("FAIL abort_hs got b=%b d=%b cnt=%0d want 0 0 %0d", busy, done, issue_cnt, exp_cnt); end
      tick();
      vec++; if (done !== 1'b0) begin errs++; $display("FAIL abort_nodone got %b want 0", done); end
   endtask

   task automatic test_async_reset();
      bus.instr_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vec++; if (bus.instr_valid !== 1'b1) begin errs++; $display("FAIL ar_run got %b want 1", bus.instr_valid); end
      #2 reset = 1'b0;
      #1;
      vec++; if (bus.instr_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL ar_drop got v=%b b=%b want 0 0", bus.instr_valid, busy); end
      vec++; if (issue_cnt !== 8'd0) begin errs++; $display("FAIL ar_cnt got %0d want 0", issue_cnt); end
      exp_cnt = 8'd0;
      #3 reset = 1'b1;
      bus.instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL ar_start got %b want 0", busy); end
   endtask

   task automatic test_wrap();
      write_word(6'h2C);
      loop = 1'b1;
      bus.instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) begin
            vec++; if (issue_cnt !== 8'd255) begin errs++; $display("FAIL wrap_255 got %0d want 255", issue_cnt); end
         end
         if (i == 100) begin
            vec++; if (bus.instr !== 6'h2C || bus.instr_valid !== 1'b1) begin errs++; $display("FAIL single_reissue got v=%b %h want v=1 2c", bus.instr_valid, bus.instr); end
         end
         tick();
      end
      vec++; if (issue_cnt !== 8'd0 || busy !== 1'b1) begin errs++; $display("FAIL wrap_0 got cnt=%0d b=%b want 0 1", issue_cnt, busy); end
      bus.instr_ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      loop = 1'b0;
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL wrap_abort got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_backpressure();
      test_loop_abort();
      test_async_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
- REQ-001: Parameter B, default 6, sets the instruction word width.
- REQ-002: Parameter DEPTH, default 8, sets the program buffer entry count; a power of 2, at least 2.
- REQ-003: clk  input  1  is the single clock; all state changes on the rising edge.
- REQ-004: reset  input  1  is the asynchronous, active-low reset; reset=0 clears all state immediately.
- REQ-005: wr_en  input  1  is the program-buffer write strobe.
- REQ-006: wr_data  input  B  is the instruction word to append.
- REQ-007: clear  input  1  empties the program buffer (honoured only in IDLE).
- REQ-008: start  input  1  begins issuing the buffered program.
- REQ-009: loop  input  1  selects replay from entry 0 after the last entry; sampled on every last-entry handshake.
- REQ-010: abort  input  1  terminates issuing.
- REQ-011: instr_valid  output  1  means an instruction is presented to the processor.
- REQ-012: instr_ready  input  1  means the processor accepts the presented instruction.
- REQ-013: instr  output  B  is the presented instruction word.
- REQ-014: full  output  1  means the buffer holds DEPTH entries.
- REQ-015: busy  output  1  means the state is RUN.
- REQ-016: done  output  1  is a one-cycle pulse on non-loop program completion.
- REQ-017: issue_cnt  output  8  is a wrapping count of accepted instructions.

Function
- REQ-018: The FSM SHALL have states IDLE, RUN and DONE, encoded in registers.
- REQ-019: In IDLE, wr_en=1 with full=0 SHALL write wr_data at entry count and increment count; in IDLE with full=1, and in RUN or DONE, writes SHALL be ignored.
- REQ-020: In IDLE, clear=1 SHALL set count to 0 and take priority over a same-cycle wr_en.
- REQ-021: IDLE -> RUN SHALL occur on start=1 with count>0 and clear=0, setting rd_ptr=0; start with count=0 SHALL be ignored.
- REQ-022: In RUN, instr_valid SHALL be 1 and instr SHALL equal buffer[rd_ptr]; outside RUN, instr_valid=0 and instr=0.
- REQ-023: A handshake is instr_valid & instr_ready on a rising edge; instr SHALL hold stable until the handshake.
- REQ-024: Each handshake SHALL increment issue_cnt modulo 256.
- REQ-025: A handshake with rd_ptr<count-1 SHALL increment rd_ptr.
- REQ-026: A handshake with rd_ptr=count-1 and loop=1 SHALL set rd_ptr=0 and stay in RUN, with no done pulse.
- REQ-027: A handshake with rd_ptr=count-1 and loop=0 SHALL go to DONE.
- REQ-028: DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; buffer contents and count are retained so a later start replays the program.
- REQ-029: abort=1 in RUN SHALL go to IDLE on that edge with no done pulse; a same-cycle handshake still counts in issue_cnt.
- REQ-030: abort in IDLE or DONE SHALL have no effect.
- REQ-031: Zero-wait throughput SHALL be one instruction per cycle with instr_ready held at 1.
- REQ-032: count=1 SHALL issue that single entry; with loop=1 it SHALL re-issue every handshake.
- REQ-033: full SHALL equal (count==DEPTH); busy SHALL equal (state==RUN); both are combinational from registers.

Reset
- REQ-034: On reset=0 the block SHALL enter IDLE with count=0, rd_ptr=0, issue_cnt=0, instr_valid=0, instr=0, done=0, busy=0 and full=0; buffer contents are don't-care.
- REQ-035: Reset asserted during RUN SHALL drop instr_valid asynchronously, without waiting for a clock edge.
- REQ-036: After reset deasserts, the block SHALL accept writes on the first rising edge.

Verification
- REQ-037: Write 0x01, 0x02, 0x03, then start with instr_ready=1 and loop=0 -> instr 1, 2, 3 on consecutive cycles, done pulses once, issue_cnt=3, back in IDLE.
- REQ-038: Write 8 entries, then a 9th write -> full=1 and the 9th write is ignored; clear -> full=0; start -> no transition.
- REQ-039: Write 0x2A, 0x15, run with instr_ready toggling 1/0 every cycle -> each word held until accepted, order 0x2A, 0x15, issue_cnt=2.
- REQ-040: Write 2 entries, run with loop=1 for 7 handshakes -> sequence e0, e1, e0, e1, e0, e1, e0, no done pulse; abort -> IDLE, issue_cnt=7.
- REQ-041: Assert reset=0 mid-RUN between clock edges -> instr_valid=0 immediately and count=0; a subsequent start is ignored.
- REQ-042: Issue 256 instructions via loop mode -> issue_cnt wraps to 0.
